// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED constants and H-matrix helpers for the syndrome and correction stages
package ecc_pkg;

    localparam logic [1:0] MODE_SMALL  = 2'b00;
    localparam logic [1:0] MODE_MEDIUM = 2'b01;
    localparam logic [1:0] MODE_LARGE  = 2'b10;

    localparam logic [1:0] NOF_NONE   = 2'b00;
    localparam logic [1:0] NOF_SINGLE = 2'b01;
    localparam logic [1:0] NOF_DOUBLE = 2'b10;

    // Column of the H matrix for codeword bit idx: check bits are powers of two,
    // the overall parity bit has no syndrome weight, data bits take the remaining
    // non-zero non-power-of-two values in ascending order.
    function automatic logic [4:0] h_col(input int idx);
        logic [4:0] r;
        int n;
        r = '0;
        n = 6;
        if (idx < 5) begin
            r = 5'(1 << idx);
        end else if (idx > 5) begin
            for (int v = 3; v < 32; v++) begin
                if ((v & (v - 1)) != 0) begin
                    if (n == idx) r = 5'(v);
                    n++;
                end
            end
        end
        return r;
    endfunction

    // Bits that belong to the codeword for a given size mode; 11 behaves as large.
    function automatic logic [31:0] mode_mask(input logic [1:0] mode);
        return (mode == MODE_SMALL)  ? 32'h0000_3FFF :
               (mode == MODE_MEDIUM) ? 32'h003F_FFFF : 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/ecc_err_counter.sv
// ecc_err_counter: saturating event counter with synchronous clear taking priority over increment
module ecc_err_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc && (cnt != '1)) cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/ecc_syndrome_check.sv
// ecc_syndrome_check: masks a SECDED codeword, computes syndrome and error class, two-stage valid/ready pipeline
module ecc_syndrome_check
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMBA_WORD-1:0] in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AMBA_WORD-1:0] DATA_OUT,
    output logic [4:0]           S,
    output logic [1:0]           NOF,
    output logic                 Small,
    output logic                 Medium,
    output logic [CNT_WIDTH-1:0] cnt_corr,
    output logic [CNT_WIDTH-1:0] cnt_uncorr,
    input  logic                 cnt_clr
);

    logic                 v1, v2;
    logic [AMBA_WORD-1:0] d1;
    logic [1:0]           m1;
    logic                 adv1, adv2;
    logic [4:0]           syn;
    logic                 par;
    logic [1:0]           nof_c;
    logic                 xfer;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = !rst && adv1;
    assign out_valid = v2;
    assign xfer      = v2 && out_ready;

    // Stage 1: capture the masked codeword and its mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            m1 <= MODE_SMALL;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= in_data & mode_mask(in_mode);
                m1 <= in_mode;
            end
        end
    end

    // Syndrome and overall parity of the stage-1 word.
    always_comb begin
        syn = '0;
        par = 1'b0;
        for (int i = 0; i < AMBA_WORD; i++) begin
            syn ^= d1[i] ? h_col(i) : 5'd0;
            par ^= d1[i];
        end
        nof_c = par ? NOF_SINGLE : ((syn != 5'd0) ? NOF_DOUBLE : NOF_NONE);
    end

    // Stage 2: register results for the correction stage; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            DATA_OUT <= '0;
            S        <= '0;
            NOF      <= NOF_NONE;
            Small    <= 1'b0;
            Medium   <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                DATA_OUT <= d1;
                S        <= syn;
                NOF      <= nof_c;
                Small    <= (m1 == MODE_SMALL);
                Medium   <= (m1 == MODE_MEDIUM);
            end
        end
    end

    ecc_err_counter #(.W(CNT_WIDTH)) u_corr (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (xfer && (NOF == NOF_SINGLE)),
        .cnt (cnt_corr)
    );

    ecc_err_counter #(.W(CNT_WIDTH)) u_uncorr (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (xfer && (NOF == NOF_DOUBLE)),
        .cnt (cnt_uncorr)
    );

endmodule

// File: tb/tb_ecc_syndrome_check.sv
// tb_ecc_syndrome_check: scoreboard bench for the syndrome stage
module tb_ecc_syndrome_check;

    localparam int CW = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  nof;
        logic        sm;
        logic        md;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic [1:0]    in_mode = 2'b10;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   DATA_OUT;
    logic [4:0]    S;
    logic [1:0]    NOF;
    logic          Small, Medium;
    logic [CW-1:0] cnt_corr, cnt_uncorr;
    logic          cnt_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    exp_t q[$];
    logic [CW-1:0] exp_corr = '0;
    logic [CW-1:0] exp_unc = '0;

    logic [4:0] col_tab [32] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0,
        5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
        5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26,
        5'd27, 5'd28, 5'd29, 5'd30, 5'd31};

    always #5 clk = ~clk;

    ecc_syndrome_check #(.AMBA_WORD(32), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .DATA_OUT   (DATA_OUT),
        .S          (S),
        .NOF        (NOF),
        .Small      (Small),
        .Medium     (Medium),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr),
        .cnt_clr    (cnt_clr)
    );

    function automatic exp_t model(input logic [31:0] d, input logic [1:0] m);
        exp_t e;
        int len;
        logic p;
        len = (m == 2'b00) ? 14 : (m == 2'b01) ? 22 : 32;
        e = '0;
        p = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (d[i]) begin
                e.d[i] = 1'b1;
                e.s = e.s ^ col_tab[i];
                p = ~p;
            end
        end
        e.nof = p ? 2'b01 : (e.s != 0) ? 2'b10 : 2'b00;
        e.sm = (m == 2'b00);
        e.md = (m == 2'b01);
        return e;
    endfunction

    // Monitor: compares each output transfer against the queue, tracks expected counters, records accepted inputs.
    always @(negedge clk) begin
        exp_t e;
        logic [40:0] got;
        if (rst) begin
            q.delete();
            exp_corr = '0;
            exp_unc = '0;
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected got data=%h S=%b NOF=%b, required no output", DATA_OUT, S, NOF);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    got = {DATA_OUT, S, NOF, Small, Medium};
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL out_word got data=%h S=%b NOF=%b sm=%b md=%b, required data=%h S=%b NOF=%b sm=%b md=%b",
                                 DATA_OUT, S, NOF, Small, Medium, e.d, e.s, e.nof, e.sm, e.md);
                    end
                    if (e.nof == 2'b01 && exp_corr != '1) exp_corr = exp_corr + 1'b1;
                    if (e.nof == 2'b10 && exp_unc != '1) exp_unc = exp_unc + 1'b1;
                end
            end
            if (cnt_clr) begin
                exp_corr = '0;
                exp_unc = '0;
            end
            if (in_valid && in_ready) q.push_back(model(in_data, in_mode));
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] m);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_mode = m;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout got in_ready=0, required 1 within 50 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (q.size() == 0);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout got %0d pending, required 0", q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_cnt(input string tag);
        n_cmp++;
        if (cnt_corr !== exp_corr || cnt_uncorr !== exp_unc) begin
            n_bad++;
            $display("FAIL %s got corr=%0d uncorr=%0d, required corr=%0d uncorr=%0d",
                     tag, cnt_corr, cnt_uncorr, exp_corr, exp_unc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, DATA_OUT, S, NOF, Small, Medium, cnt_corr, cnt_uncorr} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got ov=%b ir=%b data=%h S=%b NOF=%b cc=%0d cu=%0d, required all 0",
                     out_valid, in_ready, DATA_OUT, S, NOF, cnt_corr, cnt_uncorr);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_large();
        out_ready = 1'b1;
        send(32'h0, 2'b10);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early got out_valid=%b, required 0", out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || S !== 5'b0 || NOF !== 2'b00 || DATA_OUT !== 32'h0) begin
            n_bad++;
            $display("FAIL large_zero got ov=%b S=%b NOF=%b data=%h, required 1 00000 00 0", out_valid, S, NOF, DATA_OUT);
        end
        drain();
        check_cnt("cnt_after_zero");
        send(32'h40, 2'b10);
        @(posedge clk); #1;
        n_cmp++;
        if (S !== 5'b00011 || NOF !== 2'b01) begin
            n_bad++;
            $display("FAIL large_bit6 got S=%b NOF=%b, required 00011 01", S, NOF);
        end
        drain();
        n_cmp++;
        if (cnt_corr !== 4'd1) begin
            n_bad++;
            $display("FAIL cnt_corr_one got %0d, required 1", cnt_corr);
        end
        send(32'h20, 2'b10);
        @(posedge clk); #1;
        n_cmp++;
        if (S !== 5'b0 || NOF !== 2'b01) begin
            n_bad++;
            $display("FAIL large_parity got S=%b NOF=%b, required 00000 01", S, NOF);
        end
        send(32'h3, 2'b10);
        @(posedge clk); #1;
        n_cmp++;
        if (S !== 5'b00011 || NOF !== 2'b10) begin
            n_bad++;
            $display("FAIL large_double got S=%b NOF=%b, required 00011 10", S, NOF);
        end
        drain();
        n_cmp++;
        if (cnt_uncorr !== 4'd1) begin
            n_bad++;
            $display("FAIL cnt_uncorr_one got %0d, required 1", cnt_uncorr);
        end
    endtask

    task automatic test_modes();
        send(32'hFFFF_C008, 2'b00);
        @(posedge clk); #1;
        n_cmp++;
        if (DATA_OUT !== 32'h8 || S !== 5'b01000 || NOF !== 2'b01 || Small !== 1'b1 || Medium !== 1'b0) begin
            n_bad++;
            $display("FAIL small_mask got data=%h S=%b NOF=%b sm=%b md=%b, required 00000008 01000 01 1 0",
                     DATA_OUT, S, NOF, Small, Medium);
        end
        send(32'hFFFF_FFFF, 2'b01);
        send(32'hFFFF_FFFF, 2'b11);
        send(32'hDEAD_BEEF, 2'b10);
        drain();
        check_cnt("cnt_after_modes");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [5] = '{32'h1, 32'h3, 32'h80, 32'h21, 32'hDEAD_BEEF};
        logic [39:0] snap;
        logic acc;
        int k;
        int base;
        base = n_out;
        k = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 2'b10;
        snap = '0;
        for (int c = 0; c < 5; c++) begin
            in_data = w[k];
            @(negedge clk);
            acc = in_ready;
            if (c == 2) snap = {out_valid, DATA_OUT, S, NOF};
            if (c > 2) begin
                n_cmp++;
                if ({out_valid, DATA_OUT, S, NOF} !== snap || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stall_stable got ov=%b data=%h S=%b NOF=%b, required %h", out_valid, DATA_OUT, S, NOF, snap);
                end
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        n_cmp++;
        if (k !== 2 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_accept got accepted=%0d in_ready=%b, required 2 0", k, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && k < 5; c++) begin
            in_data = w[k];
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        drain();
        n_cmp++;
        if (n_out - base !== 5) begin
            n_bad++;
            $display("FAIL b2b_count got %0d outputs, required 5", n_out - base);
        end
        check_cnt("cnt_after_b2b");
    endtask

    task automatic test_counters();
        logic ok;
        for (int i = 0; i < 18; i++) send(32'h40, 2'b10);
        drain();
        n_cmp++;
        if (cnt_corr !== 4'hF) begin
            n_bad++;
            $display("FAIL cnt_saturate got %0d, required 15", cnt_corr);
        end
        check_cnt("cnt_saturate_model");
        out_ready = 1'b0;
        send(32'h40, 2'b10);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        n_cmp++;
        if (cnt_corr !== 4'd0 || cnt_uncorr !== 4'd0 || !ok) begin
            n_bad++;
            $display("FAIL cnt_clear got corr=%0d uncorr=%0d seen_valid=%b, required 0 0 1", cnt_corr, cnt_uncorr, ok);
        end
        in_valid = 1'b1;
        in_data = 32'h40;
        in_mode = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || cnt_corr !== 4'd0 || DATA_OUT !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset got ov=%b ir=%b cc=%0d data=%h, required 0 0 0 0", out_valid, in_ready, cnt_corr, DATA_OUT);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        send(32'h80, 2'b10);
        drain();
        n_cmp++;
        if (cnt_corr !== 4'd1) begin
            n_bad++;
            $display("FAIL post_reset_cnt got %0d, required 1", cnt_corr);
        end
    endtask

    initial begin
        test_reset();
        test_large();
        test_modes();
        test_back_to_back();
        test_counters();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover got %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
